// File: rtl/alarm_ctrl_pkg.sv
// alarm_ctrl_pkg: shared definitions for the alarm unit.
//   state_t      - FSM state encodings, also the o_state output encoding
//   POS_SEC/MIN  - i_set_pos values selecting the edited alarm field
//   inc_wrap()   - increment of a 0..59 time field with wrap to 0
package alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZED  = 2'd3
  } state_t;

  localparam logic POS_SEC = 1'b0;
  localparam logic POS_MIN = 1'b1;

  localparam logic [5:0] FIELD_MAX = 6'd59;

  // Values above 59 never occur in the alarm registers, but treat them as
  // the wrap point anyway so a corrupted field recovers on the next press.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v);
    return (v >= FIELD_MAX) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// alarm_ctrl_if: running time bundle from the minsec counter pair.
//   sec - running seconds 0..59 (foreign clock domain)
//   min - running minutes 0..59 (foreign clock domain)
// There is no handshake: the producer simply updates the values and the
// consumer resamples them every clock; master = counter side, slave = alarm.
interface alarm_ctrl_if;
  logic [5:0] sec;
  logic [5:0] min;

  modport master (output sec, output min);
  modport slave  (input sec, input min);
endinterface

// File: rtl/alarm_time_sync.sv
// alarm_time_sync: brings the foreign-domain {min,sec} into clk.
//   clk, rst_n  - clock, async active-low reset
//   time_in     - running time bundle (slave side)
//   stable_sec  - filtered seconds
//   stable_min  - filtered minutes
//   sec_tick    - one clk wide, filtered seconds changed
//   changed     - one clk wide, filtered time changed
module alarm_time_sync (
  input  logic         clk,
  input  logic         rst_n,
  alarm_ctrl_if.slave  time_in,
  output logic [5:0]   stable_sec,
  output logic [5:0]   stable_min,
  output logic         sec_tick,
  output logic         changed
);

  logic [11:0] s1;
  logic [11:0] s2;
  logic [11:0] s2_d;
  logic [11:0] stable;
  logic [11:0] prev;

  // The stable register only loads once the synchronised word has been
  // identical for two consecutive clocks, so bits that cross the domain on
  // different clocks never produce an intermediate value downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      s2_d   <= '0;
      stable <= '0;
      prev   <= '0;
    end else begin
      s1   <= {time_in.min, time_in.sec};
      s2   <= s1;
      s2_d <= s2;
      if (s2 == s2_d) begin
        stable <= s2;
      end
      prev <= stable;
    end
  end

  assign stable_sec = stable[5:0];
  assign stable_min = stable[11:6];
  assign sec_tick   = (stable[5:0] != prev[5:0]);
  assign changed    = (stable != prev);

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm time setup, arm/ring/snooze FSM and buzzer tone.
//   clk, rst_n             - 50 MHz clock, async active-low reset
//   i_sec, i_min           - running time (foreign domain)
//   i_set_mode, i_set_pos  - setup level, field select (0 sec, 1 min)
//   i_inc, i_arm, i_stop   - one-clk pulses in clk domain
//   o_alarm_sec/min        - alarm time
//   o_state                - 0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZED
//   o_armed, o_ringing     - status decodes of the state register
//   o_buzz                 - buzzer square wave, active only while ringing
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_SEC = 10,
  parameter int TONE_HALF  = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic       i_set_mode,
  input  logic       i_set_pos,
  input  logic       i_inc,
  input  logic       i_arm,
  input  logic       i_stop,
  output logic [5:0] o_alarm_sec,
  output logic [5:0] o_alarm_min,
  output logic [1:0] o_state,
  output logic       o_armed,
  output logic       o_ringing,
  output logic       o_buzz
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam int TW = $clog2(TONE_HALF + 1);

  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);
  localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_HALF - 1);

  alarm_ctrl_if time_bus ();
  assign time_bus.sec = i_sec;
  assign time_bus.min = i_min;

  logic [5:0] stable_sec;
  logic [5:0] stable_min;
  logic       sec_tick;
  logic       changed;

  alarm_time_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_in    (time_bus),
    .stable_sec (stable_sec),
    .stable_min (stable_min),
    .sec_tick   (sec_tick),
    .changed    (changed)
  );

  state_t        state;
  logic [5:0]    alarm_sec;
  logic [5:0]    alarm_min;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snooze_cnt;
  logic [TW-1:0] tone_cnt;
  logic          buzz;
  logic          match;

  // Fires only on entry into the alarm time, so an alarm set equal to the
  // current time waits until that time comes round again.
  assign match = changed && ({stable_min, stable_sec} == {alarm_min, alarm_sec});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_DISARMED;
      alarm_sec  <= '0;
      alarm_min  <= '0;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      tone_cnt   <= '0;
      buzz       <= 1'b0;
    end else begin
      if (i_set_mode) begin
        if (i_inc) begin
          if (i_set_pos == POS_MIN) begin
            alarm_min <= inc_wrap(alarm_min);
          end else begin
            alarm_sec <= inc_wrap(alarm_sec);
          end
        end
        if (state == ST_RINGING || state == ST_SNOOZED) begin
          state <= ST_ARMED;
        end
      end else begin
        unique case (state)
          ST_DISARMED: begin
            if (i_arm) state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (i_arm) begin
              state <= ST_DISARMED;
            end else if (match) begin
              state    <= ST_RINGING;
              ring_cnt <= '0;
            end
          end
          ST_RINGING: begin
            if (i_arm) begin
              state <= ST_DISARMED;
            end else if (i_stop) begin
              state      <= ST_SNOOZED;
              snooze_cnt <= '0;
            end else if (sec_tick) begin
              ring_cnt <= ring_cnt + 1'b1;
              if (ring_cnt == RING_LAST) state <= ST_ARMED;
            end
          end
          ST_SNOOZED: begin
            if (i_arm) begin
              state <= ST_DISARMED;
            end else if (i_stop) begin
              state <= ST_ARMED;
            end else if (sec_tick) begin
              snooze_cnt <= snooze_cnt + 1'b1;
              if (snooze_cnt == SNOOZE_LAST) begin
                state    <= ST_RINGING;
                ring_cnt <= '0;
              end
            end
          end
          default: state <= ST_DISARMED;
        endcase
      end

      // Tone follows the registered state, so the buzzer clears one clock
      // after leaving RINGING and the first edge lands TONE_HALF clocks in.
      if (state == ST_RINGING) begin
        if (tone_cnt == TONE_LAST) begin
          tone_cnt <= '0;
          buzz     <= ~buzz;
        end else begin
          tone_cnt <= tone_cnt + 1'b1;
        end
      end else begin
        tone_cnt <= '0;
        buzz     <= 1'b0;
      end
    end
  end

  assign o_alarm_sec = alarm_sec;
  assign o_alarm_min = alarm_min;
  assign o_state     = state;
  assign o_armed     = (state != ST_DISARMED);
  assign o_ringing   = (state == ST_RINGING);
  assign o_buzz      = buzz;

endmodule
